// File: rtl/dac_frame_rx.sv
// rtl/dac_frame_rx.sv - DAC serial link frame receiver with first-word-fall-through readback FIFO
// Optional idle-timeout abort is compiled in when DACRX_TIMEOUT_EN is defined.
module dac_frame_rx #(
    parameter int FRAME_BITS     = 24,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic                          syncDac,
    input  logic                          sclkDac,
    input  logic                          sdiDac,
    input  logic                          rdEn,
    input  logic                          clrErr,
    output logic [FRAME_BITS-1:0]         frameData,
    output logic                          frameValid,
    output logic [$clog2(FIFO_DEPTH):0]   frameCount,
    output logic                          errFrame,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(FRAME_BITS + 2);

`ifdef DACRX_TIMEOUT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_ABORT} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

    logic [2:0]            sync_pipe_q, sync_pipe_d;
    logic [2:0]            sclk_pipe_q, sclk_pipe_d;
    logic [1:0]            sdi_pipe_q, sdi_pipe_d;
    logic [1:0]            warm_q, warm_d;
    state_t                state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  push_q, push_d;
    logic [FRAME_BITS-1:0] push_data_q, push_data_d;
    logic                  err_pend_q, err_pend_d;
    logic                  err_q, err_d;
    logic                  rd_req_q, rd_req_d;
    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic [FRAME_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [FRAME_BITS-1:0] mem_d [FIFO_DEPTH];
`ifdef DACRX_TIMEOUT_EN
    logic [7:0]            idle_cnt_q, idle_cnt_d;
`endif

    logic                  fall_sync, rise_sync, fall_sclk, sdi;
    logic [BW-1:0]         next_cnt;
    logic [FRAME_BITS-1:0] next_shift;
    logic [CW-1:0]         fifo_cnt;
    logic                  fifo_full, do_pop, do_push;

    // The sync chain resets high, so a pin held low through reset would look like a
    // falling edge until real samples reach s3; starts are ignored until then.
    assign fall_sync = ~sync_pipe_q[1] & sync_pipe_q[2] & (&warm_q);
    assign rise_sync = sync_pipe_q[1] & ~sync_pipe_q[2];
    assign fall_sclk = ~sclk_pipe_q[1] & sclk_pipe_q[2];
    assign sdi       = sdi_pipe_q[1];

    always_comb begin
        sync_pipe_d = {sync_pipe_q[1:0], syncDac};
        sclk_pipe_d = {sclk_pipe_q[1:0], sclkDac};
        sdi_pipe_d  = {sdi_pipe_q[0], sdiDac};
        warm_d      = (&warm_q) ? warm_q : warm_q + 2'd1;
        err_d       = err_pend_q;
        rd_req_d    = rdEn & frameValid;
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        err_pend_d  = 1'b0;
        next_cnt    = bit_cnt_q;
        next_shift  = shift_q;
`ifdef DACRX_TIMEOUT_EN
        idle_cnt_d  = idle_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fall_sync) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    shift_d   = '0;
`ifdef DACRX_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                end
            end
            ST_SHIFT: begin
                // A coincident sclk fall is applied before the length check at sync rise.
                if (fall_sclk) begin
                    next_shift = {shift_q[FRAME_BITS-2:0], sdi};
                    next_cnt   = (bit_cnt_q == BW'(FRAME_BITS + 1)) ? bit_cnt_q
                                                                    : bit_cnt_q + 1'b1;
                end
                shift_d   = next_shift;
                bit_cnt_d = next_cnt;
                if (rise_sync) begin
                    state_d = ST_IDLE;
                    if (next_cnt == BW'(FRAME_BITS)) begin
                        push_d      = 1'b1;
                        push_data_d = next_shift;
                    end else begin
                        err_pend_d  = 1'b1;
                    end
                end
`ifdef DACRX_TIMEOUT_EN
                else if (fall_sclk) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == 8'(TIMEOUT_CYCLES)) begin
                    err_pend_d = 1'b1;
                    state_d    = ST_ABORT;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
`endif
            end
`ifdef DACRX_TIMEOUT_EN
            ST_ABORT: begin
                if (rise_sync) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign fifo_cnt  = wr_ptr_q - rd_ptr_q;
    assign fifo_full = (fifo_cnt == CW'(FIFO_DEPTH));
    assign do_pop    = rd_req_q && (fifo_cnt != '0);
    assign do_push   = push_q && (!fifo_full || do_pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data_q;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_q && !do_push) begin
            overflow_d = 1'b1;
        end else if (clrErr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            sync_pipe_q <= 3'b111;
            sclk_pipe_q <= 3'b111;
            sdi_pipe_q  <= 2'b00;
            warm_q      <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            err_pend_q  <= 1'b0;
            err_q       <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            mem_q       <= '{default: '0};
`ifdef DACRX_TIMEOUT_EN
            idle_cnt_q  <= '0;
`endif
        end else begin
            sync_pipe_q <= sync_pipe_d;
            sclk_pipe_q <= sclk_pipe_d;
            sdi_pipe_q  <= sdi_pipe_d;
            warm_q      <= warm_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            err_pend_q  <= err_pend_d;
            err_q       <= err_d;
            rd_req_q    <= rd_req_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            mem_q       <= mem_d;
`ifdef DACRX_TIMEOUT_EN
            idle_cnt_q  <= idle_cnt_d;
`endif
        end
    end

    assign frameData  = mem_q[rd_ptr_q[AW-1:0]];
    assign frameValid = (fifo_cnt != '0);
    assign frameCount = fifo_cnt;
    assign errFrame   = err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_dac_frame_rx.sv
// tb/tb_dac_frame_rx.sv - self-checking bench for dac_frame_rx against a queue-based frame model
module tb_dac_frame_rx;

    localparam int FB    = 24;
    localparam int DEPTH = 4;
`ifdef DACRX_TIMEOUT_EN
    localparam int EXP_STALL = 1;
    localparam int EXP_CLOSE = 0;
`else
    localparam int EXP_STALL = 0;
    localparam int EXP_CLOSE = 1;
`endif

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          syncDac = 1'b1;
    logic          sclkDac = 1'b1;
    logic          sdiDac = 1'b0;
    logic          rdEn = 1'b0;
    logic          clrErr = 1'b0;
    logic [FB-1:0] frameData;
    logic          frameValid;
    logic [2:0]    frameCount;
    logic          errFrame;
    logic          overflow;

    int total = 0;
    int bad = 0;
    int err_seen = 0;
    int m_err = 0;
    logic [FB-1:0] mq[$];
    logic m_ovf = 1'b0;

    dac_frame_rx #(.FRAME_BITS(FB), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rstN(rstN), .syncDac(syncDac), .sclkDac(sclkDac), .sdiDac(sdiDac),
        .rdEn(rdEn), .clrErr(clrErr), .frameData(frameData), .frameValid(frameValid),
        .frameCount(frameCount), .errFrame(errFrame), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (errFrame === 1'b1) err_seen++;

    initial begin
        #900000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        sdiDac = b;
        tick(2);
        sclkDac = 1'b0;
        tick(2);
        sclkDac = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] d, input int nbits, input bit rd_mid);
        syncDac = 1'b0;
        tick(2);
        for (int i = nbits - 1; i >= 0; i--) drive_bit(d[i]);
        tick(2);
        syncDac = 1'b1;
        if (rd_mid) begin
            tick(2);
            rdEn = 1'b1;
            tick(1);
            rdEn = 1'b0;
            tick(2);
        end else begin
            tick(5);
        end
        if (rd_mid && mq.size() > 0) void'(mq.pop_front());
        if (nbits == FB) begin
            if (mq.size() < DEPTH) mq.push_back(d[FB-1:0]);
            else m_ovf = 1'b1;
        end else begin
            m_err++;
        end
    endtask

    task automatic pop_word(output logic [FB-1:0] w);
        w = frameData;
        rdEn = 1'b1;
        tick(1);
        rdEn = 1'b0;
        tick(1);
    endtask

    task automatic test_reset;
        rstN = 1'b0;
        tick(3);
        total++; if (frameValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", frameValid); end
        total++; if (frameCount !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", frameCount); end
        total++; if (frameData !== 24'h0) begin bad++; $display("FAIL reset_data got=%0h exp=0", frameData); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0h exp=0", overflow); end
        total++; if (errFrame !== 1'b0) begin bad++; $display("FAIL reset_err got=%0h exp=0", errFrame); end
        rstN = 1'b1;
        tick(4);
    endtask

    task automatic test_good_frame;
        logic [FB-1:0] d;
        d = 24'h3A5C0F;
        syncDac = 1'b0;
        tick(2);
        for (int i = FB - 1; i >= 0; i--) drive_bit(d[i]);
        tick(2);
        syncDac = 1'b1;
        tick(3);
        total++; if (frameValid !== 1'b0) begin bad++; $display("FAIL good_early got=%0h exp=0", frameValid); end
        tick(1);
        mq.push_back(d);
        total++; if (frameValid !== 1'b1) begin bad++; $display("FAIL good_valid got=%0h exp=1", frameValid); end
        total++; if (frameData !== mq[0]) begin bad++; $display("FAIL good_data got=%0h exp=%0h", frameData, mq[0]); end
        total++; if (frameCount !== 3'd1) begin bad++; $display("FAIL good_count got=%0d exp=1", frameCount); end
        rdEn = 1'b1;
        tick(1);
        rdEn = 1'b0;
        total++; if (frameCount !== 3'd1) begin bad++; $display("FAIL read_lat got=%0d exp=1", frameCount); end
        tick(1);
        void'(mq.pop_front());
        total++; if (frameValid !== 1'b0) begin bad++; $display("FAIL read_valid got=%0h exp=0", frameValid); end
        total++; if (frameCount !== 3'd0) begin bad++; $display("FAIL read_count got=%0d exp=0", frameCount); end
    endtask

    task automatic test_short_long;
        int e0;
        e0 = err_seen;
        m_err = 0;
        send_frame(32'h0000_BEEF, 16, 1'b0);
        send_frame(32'h01AB_CDEF, 25, 1'b0);
        total++; if (err_seen !== e0 + m_err) begin bad++; $display("FAIL shortlong_err got=%0d exp=%0d", err_seen - e0, m_err); end
        total++; if (frameCount !== 3'(mq.size())) begin bad++; $display("FAIL shortlong_count got=%0d exp=%0d", frameCount, mq.size()); end
        rdEn = 1'b1;
        tick(1);
        rdEn = 1'b0;
        tick(2);
        total++; if (frameCount !== 3'd0) begin bad++; $display("FAIL empty_read got=%0d exp=0", frameCount); end
    endtask

    task automatic test_overflow;
        logic [FB-1:0] w;
        logic [FB-1:0] e;
        for (int i = 1; i <= 5; i++) send_frame(32'(i), FB, 1'b0);
        total++; if (frameCount !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", frameCount); end
        total++; if (overflow !== m_ovf) begin bad++; $display("FAIL ovf_flag got=%0h exp=%0h", overflow, m_ovf); end
        for (int i = 0; i < 4; i++) begin
            e = mq.pop_front();
            pop_word(w);
            total++; if (w !== e) begin bad++; $display("FAIL ovf_read%0d got=%0h exp=%0h", i, w, e); end
        end
        clrErr = 1'b1;
        tick(1);
        clrErr = 1'b0;
        m_ovf = 1'b0;
        tick(1);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0h exp=0", overflow); end
    endtask

    task automatic test_push_pop_full;
        logic [FB-1:0] w;
        logic [FB-1:0] e;
        for (int i = 1; i <= 4; i++) send_frame(32'(i), FB, 1'b0);
        send_frame(32'h5, FB, 1'b1);
        total++; if (overflow !== m_ovf) begin bad++; $display("FAIL pp_ovf got=%0h exp=%0h", overflow, m_ovf); end
        total++; if (frameCount !== 3'(mq.size())) begin bad++; $display("FAIL pp_count got=%0d exp=%0d", frameCount, mq.size()); end
        while (mq.size() > 0) begin
            e = mq.pop_front();
            pop_word(w);
            total++; if (w !== e) begin bad++; $display("FAIL pp_read got=%0h exp=%0h", w, e); end
        end
        total++; if (frameValid !== 1'b0) begin bad++; $display("FAIL pp_drain got=%0h exp=0", frameValid); end
    endtask

    task automatic test_reset_mid_frame;
        logic [FB-1:0] d;
        logic [FB-1:0] w;
        int e0;
        e0 = err_seen;
        d = 24'hC3A5F0;
        syncDac = 1'b0;
        tick(2);
        for (int i = FB - 1; i >= 14; i--) drive_bit(d[i]);
        rstN = 1'b0;
        tick(2);
        rstN = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        for (int i = 13; i >= 0; i--) drive_bit(d[i]);
        tick(2);
        syncDac = 1'b1;
        tick(5);
        total++; if (frameCount !== 3'd0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", frameCount); end
        total++; if (err_seen !== e0) begin bad++; $display("FAIL rstmid_err got=%0d exp=0", err_seen - e0); end
        send_frame({8'h0, $urandom_range(0, 32'hFF_FFFF)}, FB, 1'b0);
        total++; if (frameCount !== 3'(mq.size())) begin bad++; $display("FAIL rstmid_next got=%0d exp=%0d", frameCount, mq.size()); end
        total++; if (frameData !== mq[0]) begin bad++; $display("FAIL rstmid_data got=%0h exp=%0h", frameData, mq[0]); end
        void'(mq.pop_front());
        pop_word(w);
    endtask

    task automatic test_timeout;
        int e0;
        e0 = err_seen;
        syncDac = 1'b0;
        tick(2);
        for (int i = 0; i < 5; i++) drive_bit(i[0]);
        tick(300);
        total++; if (err_seen - e0 !== EXP_STALL) begin bad++; $display("FAIL timeout_stall got=%0d exp=%0d", err_seen - e0, EXP_STALL); end
        syncDac = 1'b1;
        tick(6);
        total++; if (err_seen - e0 !== EXP_STALL + EXP_CLOSE) begin bad++; $display("FAIL timeout_close got=%0d exp=%0d", err_seen - e0, EXP_STALL + EXP_CLOSE); end
        total++; if (frameCount !== 3'd0) begin bad++; $display("FAIL timeout_count got=%0d exp=0", frameCount); end
    endtask

    task automatic test_random;
        logic [FB-1:0] w;
        logic [FB-1:0] e;
        int e0;
        int r;
        int nb;
        e0 = err_seen;
        m_err = 0;
        for (int it = 0; it < 24; it++) begin
            if (mq.size() > 0 && $urandom_range(0, 2) == 0) begin
                e = mq.pop_front();
                pop_word(w);
                total++; if (w !== e) begin bad++; $display("FAIL rnd_read%0d got=%0h exp=%0h", it, w, e); end
            end
            if ($urandom_range(0, 7) == 0) begin
                clrErr = 1'b1;
                tick(1);
                clrErr = 1'b0;
                m_ovf = 1'b0;
            end
            r = $urandom_range(0, 9);
            nb = (r < 7) ? FB : ((r == 7) ? FB - 1 : FB + 1);
            send_frame($urandom(), nb, 1'b0);
            total++; if (frameCount !== 3'(mq.size())) begin bad++; $display("FAIL rnd_count%0d got=%0d exp=%0d", it, frameCount, mq.size()); end
            total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf%0d got=%0h exp=%0h", it, overflow, m_ovf); end
            total++; if (err_seen - e0 !== m_err) begin bad++; $display("FAIL rnd_err%0d got=%0d exp=%0d", it, err_seen - e0, m_err); end
            if (mq.size() > 0) begin
                total++; if (frameData !== mq[0]) begin bad++; $display("FAIL rnd_head%0d got=%0h exp=%0h", it, frameData, mq[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_short_long();
        test_overflow();
        test_push_pop_full();
        test_reset_mid_frame();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
